// File: rtl/ones_counter_acc_pkg.sv
// Shared constants for the ones counter: mode encodings and count-width helper.
// Pure definitions, no logic; no latency or backpressure involved.
package ones_counter_acc_pkg;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_ACC    = 1'b1;

    // Bits needed to hold a popcount of an n-bit value (0..n inclusive).
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ones_counter_acc_popcount_half.sv
// Combinational popcount of a W-bit slice.
// Zero latency; no flow control.
module popcount_half #(
    parameter int W  = 3,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_dat,
    output logic [CW-1:0] o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < W; i++) begin
            o_cnt = o_cnt + CW'(i_dat[i]);
        end
    end

endmodule

// File: rtl/ones_counter_acc.sv
// Two-stage pipelined ones counter with saturating accumulator and peak tracker.
// Latency 2 cycles, 1 sample/cycle; no backpressure (input is always accepted).
module ones_counter_acc
    import ones_counter_acc_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int CNT_W = $clog2(N_IN + 1),
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    input  logic             mode,
    input  logic             clear,
    output logic             out_valid,
    output logic [CNT_W-1:0] count,
    output logic [ACC_W-1:0] acc,
    output logic             acc_sat,
    output logic [CNT_W-1:0] peak
);

    // Odd widths put the extra bit in the upper half.
    localparam int LO_W  = N_IN / 2;
    localparam int HI_W  = N_IN - LO_W;
    localparam int LO_CW = cnt_w(LO_W);
    localparam int HI_CW = cnt_w(HI_W);

    logic [LO_CW-1:0] w_lo_cnt;
    logic [HI_CW-1:0] w_hi_cnt;
    logic [LO_CW-1:0] r_lo_cnt;
    logic [HI_CW-1:0] r_hi_cnt;
    logic             r_mode;
    logic             r_v1;

    logic [CNT_W-1:0] w_c;
    logic [ACC_W:0]   w_sum;

    logic             r_out_valid;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_sat;
    logic [CNT_W-1:0] r_peak;

    popcount_half #(.W(LO_W), .CW(LO_CW)) u_pc_lo (
        .i_dat (in_data[LO_W-1:0]),
        .o_cnt (w_lo_cnt)
    );

    popcount_half #(.W(HI_W), .CW(HI_CW)) u_pc_hi (
        .i_dat (in_data[N_IN-1:LO_W]),
        .o_cnt (w_hi_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lo_cnt <= '0;
            r_hi_cnt <= '0;
            r_mode   <= MODE_SINGLE;
            r_v1     <= 1'b0;
        end else begin
            r_lo_cnt <= w_lo_cnt;
            r_hi_cnt <= w_hi_cnt;
            r_mode   <= mode;
            r_v1     <= in_valid;
        end
    end

    assign w_c   = CNT_W'(r_lo_cnt) + CNT_W'(r_hi_cnt);
    assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(w_c);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
            r_peak      <= '0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_count <= w_c;
            end
            // clear overrides any accumulate/peak update landing on the same edge
            if (clear) begin
                r_acc     <= '0;
                r_acc_sat <= 1'b0;
                r_peak    <= '0;
            end else if (r_v1) begin
                if (r_mode == MODE_SINGLE) begin
                    r_acc <= ACC_W'(w_c);
                end else if (w_sum[ACC_W]) begin
                    r_acc     <= '1;
                    r_acc_sat <= 1'b1;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                end
                if (w_c > r_peak) begin
                    r_peak <= w_c;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign acc       = r_acc;
    assign acc_sat   = r_acc_sat;
    assign peak      = r_peak;

endmodule

// File: tb/tb_ones_counter_acc.sv
// Directed bench for ones_counter_acc at N_IN=7, ACC_W=8.
module tb_ones_counter_acc;

    logic       clk;
    logic       rstn;
    logic       in_valid;
    logic [6:0] in_data;
    logic       mode;
    logic       clear;
    logic       out_valid;
    logic [2:0] count;
    logic [7:0] acc;
    logic       acc_sat;
    logic [2:0] peak;

    int errors = 0;
    int checks = 0;

    ones_counter_acc #(.N_IN(7), .CNT_W(3), .ACC_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .clear     (clear),
        .out_valid (out_valid),
        .count     (count),
        .acc       (acc),
        .acc_sat   (acc_sat),
        .peak      (peak)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; clear = 1'b0;
        #2;
        checks++;
        if ({out_valid, count, acc, acc_sat, peak} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b cnt=%0d acc=%0d sat=%b pk=%0d want all 0",
                     out_valid, count, acc, acc_sat, peak);
        end
        tick(); tick();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({out_valid, count, acc, acc_sat, peak} !== 16'h0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got ov=%b cnt=%0d acc=%0d sat=%b pk=%0d want all 0",
                         i, out_valid, count, acc, acc_sat, peak);
            end
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 7'b1011001; mode = 1'b0;
        tick();
        in_valid = 1'b0; in_data = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: out_valid=%b want 0 after one edge", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || count !== 3'd4 || acc !== 8'd4 || peak !== 3'd4) begin
            errors++;
            $display("FAIL single_result: got ov=%b cnt=%0d acc=%0d pk=%0d want ov=1 cnt=4 acc=4 pk=4",
                     out_valid, count, acc, peak);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL single_hold: got ov=%b cnt=%0d want ov=0 cnt=4", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] vec [3];
        logic [2:0] exp_cnt [3];
        logic [7:0] exp_acc [3];
        vec[0] = 7'b1111111; exp_cnt[0] = 3'd7; exp_acc[0] = 8'd7;
        vec[1] = 7'b0000000; exp_cnt[1] = 3'd0; exp_acc[1] = 8'd7;
        vec[2] = 7'b0101010; exp_cnt[2] = 3'd3; exp_acc[2] = 8'd10;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            in_data  = (i < 3) ? vec[i] : 7'b0;
            tick();
            if (i >= 1 && i <= 3) begin
                checks++;
                if (out_valid !== 1'b1 || count !== exp_cnt[i-1] || acc !== exp_acc[i-1] || peak !== 3'd7) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got ov=%b cnt=%0d acc=%0d pk=%0d want ov=1 cnt=%0d acc=%0d pk=7",
                             i-1, out_valid, count, acc, peak, exp_cnt[i-1], exp_acc[i-1]);
                end
            end
        end
    endtask

    // Lower half is bits [2:0]; bit 6 and bit 3 both belong to the upper half.
    task automatic test_halves();
        logic [6:0] vec [3];
        logic [2:0] exp_cnt [3];
        vec[0] = 7'b1000000; exp_cnt[0] = 3'd1;
        vec[1] = 7'b0001000; exp_cnt[1] = 3'd1;
        vec[2] = 7'b0000111; exp_cnt[2] = 3'd3;
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            in_data  = (i < 3) ? vec[i] : 7'b0;
            tick();
            if (i >= 1 && i <= 3) begin
                checks++;
                if (out_valid !== 1'b1 || count !== exp_cnt[i-1] || acc !== {5'b0, exp_cnt[i-1]}) begin
                    errors++;
                    $display("FAIL halves[%0d]: got ov=%b cnt=%0d acc=%0d want ov=1 cnt=%0d acc=%0d",
                             i-1, out_valid, count, acc, exp_cnt[i-1], exp_cnt[i-1]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int k;
        k = 0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mode = 1'b1;
        for (int i = 0; i < 42; i++) begin
            in_valid = (i < 40);
            in_data  = 7'b1111111;
            tick();
            if (out_valid === 1'b1) begin
                k++;
                if (k == 36) begin
                    checks++;
                    if (acc !== 8'd252 || acc_sat !== 1'b0) begin
                        errors++;
                        $display("FAIL sat_36: got acc=%0d sat=%b want acc=252 sat=0", acc, acc_sat);
                    end
                end
                if (k == 37) begin
                    checks++;
                    if (acc !== 8'd255 || acc_sat !== 1'b1) begin
                        errors++;
                        $display("FAIL sat_37: got acc=%0d sat=%b want acc=255 sat=1", acc, acc_sat);
                    end
                end
                if (k == 40) begin
                    checks++;
                    if (acc !== 8'd255 || acc_sat !== 1'b1) begin
                        errors++;
                        $display("FAIL sat_40: got acc=%0d sat=%b want acc=255 sat=1", acc, acc_sat);
                    end
                end
            end
        end
        checks++;
        if (k !== 40) begin
            errors++;
            $display("FAIL sat_outputs: got %0d valid outputs want 40", k);
        end
        // A single-mode load replaces acc but leaves the sticky flag set.
        in_valid = 1'b1; in_data = 7'b0000001; mode = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (acc !== 8'd1 || acc_sat !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL sat_sticky: got acc=%0d sat=%b cnt=%0d want acc=1 sat=1 cnt=1", acc, acc_sat, count);
        end
    endtask

    task automatic test_clear_collide();
        in_valid = 1'b1; in_data = 7'b0000111; mode = 1'b1;
        tick();
        in_valid = 1'b0; in_data = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || count !== 3'd3 || acc !== 8'd0 || acc_sat !== 1'b0 || peak !== 3'd0) begin
            errors++;
            $display("FAIL clear_collide: got ov=%b cnt=%0d acc=%0d sat=%b pk=%0d want ov=1 cnt=3 acc=0 sat=0 pk=0",
                     out_valid, count, acc, acc_sat, peak);
        end
        in_valid = 1'b1; in_data = 7'b0000011; mode = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || acc !== 8'd2 || peak !== 3'd2) begin
            errors++;
            $display("FAIL clear_next: got ov=%b acc=%0d pk=%0d want ov=1 acc=2 pk=2", out_valid, acc, peak);
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; in_data = 7'b1111111; mode = 1'b1;
        tick();
        in_data = 7'b0111111;
        tick();
        // first sample now at the output, second in stage 1, third on the input
        in_data = 7'b0011111;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({out_valid, count, acc, acc_sat, peak} !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: got ov=%b cnt=%0d acc=%0d sat=%b pk=%0d want all 0",
                     out_valid, count, acc, acc_sat, peak);
        end
        in_valid = 1'b0; in_data = '0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || acc !== 8'd0) begin
                errors++;
                $display("FAIL rst_dropped[%0d]: got ov=%b acc=%0d want ov=0 acc=0", i, out_valid, acc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_halves();
        test_saturate();
        test_clear_collide();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
